// File: rtl/machine_trap_ctrl.sv
// Machine-mode trap and CSR unit beside EX: Zicsr ops on the M-mode CSRs, synchronised local
// interrupts, fixed-priority trap selection and a RUN/REDIRECT FSM issuing one-cycle redirects.
module machine_trap_ctrl #(
  parameter int               XLEN        = 32,
  parameter int               NUM_IRQ     = 4,
  parameter logic [XLEN-1:0]  RESET_MTVEC = 32'h4,
  parameter bit               VECTORED_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_valid,
  input  logic [2:0]        csr_funct3,
  input  logic [11:0]       csr_addr,
  input  logic [XLEN-1:0]   csr_wdata,
  input  logic              csr_src_zero,
  input  logic              ecall,
  input  logic              ebreak,
  input  logic              mret,
  input  logic              exc_instr_mis,
  input  logic              exc_load_mis,
  input  logic              exc_store_mis,
  input  logic [XLEN-1:0]   exc_addr,
  input  logic [XLEN-1:0]   pc_ex,
  input  logic              irq_ok,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic              csr_rd_en,
  output logic [XLEN-1:0]   csr_rd_dat,
  output logic              trap_take,
  output logic              mret_take,
  output logic [XLEN-1:0]   trap_addr
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  typedef enum logic {ST_RUN, ST_REDIRECT} state_t;

  state_t            state_reg;
  logic              trap_take_reg;
  logic              mret_take_reg;
  logic [XLEN-1:0]   trap_addr_reg;
  logic              csr_rd_en_reg;
  logic [XLEN-1:0]   csr_rd_dat_reg;

  logic              mstatus_mie_reg;
  logic              mstatus_mpie_reg;
  logic [XLEN-1:0]   mie_reg;
  logic [XLEN-1:0]   mtvec_reg;
  logic [XLEN-1:0]   mscratch_reg;
  logic [XLEN-1:0]   mepc_reg;
  logic [XLEN-1:0]   mcause_reg;
  logic [XLEN-1:0]   mtval_reg;
  logic [NUM_IRQ-1:0] irq_sync1_reg;
  logic [NUM_IRQ-1:0] irq_sync2_reg;

  logic [XLEN-1:0]   irq_mask;
  logic [XLEN-1:0]   mip_val;
  logic [XLEN-1:0]   mstatus_val;

  // Writable interrupt-enable/pending positions: bits 16..16+NUM_IRQ-1.
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_irq_mask
    assign irq_mask[gi] = (gi >= 16) && (gi < 16 + NUM_IRQ);
  end

  always_comb begin
    mip_val = '0;
    mip_val[16 +: NUM_IRQ] = irq_sync2_reg;
    mstatus_val = '0;
    mstatus_val[3]     = mstatus_mie_reg;
    mstatus_val[7]     = mstatus_mpie_reg;
    mstatus_val[12:11] = 2'b11;
  end

  // CSR read mux and address decode
  logic            addr_ok;
  logic [XLEN-1:0] csr_old;
  always_comb begin
    addr_ok = 1'b1;
    csr_old = '0;
    case (csr_addr)
      ADDR_MSTATUS:  csr_old = mstatus_val;
      ADDR_MIE:      csr_old = mie_reg;
      ADDR_MTVEC:    csr_old = mtvec_reg;
      ADDR_MSCRATCH: csr_old = mscratch_reg;
      ADDR_MEPC:     csr_old = mepc_reg;
      ADDR_MCAUSE:   csr_old = mcause_reg;
      ADDR_MTVAL:    csr_old = mtval_reg;
      ADDR_MIP:      csr_old = mip_val;
      default:       addr_ok = 1'b0;
    endcase
  end

  logic            funct3_ok;
  logic            csr_wr;
  logic [XLEN-1:0] csr_new;
  always_comb begin
    funct3_ok = (csr_funct3[1:0] != 2'b00);
    csr_wr    = (csr_funct3[1:0] == 2'b01) || !csr_src_zero;
    case (csr_funct3[1:0])
      2'b01:   csr_new = csr_wdata;
      2'b10:   csr_new = csr_old | csr_wdata;
      2'b11:   csr_new = csr_old & ~csr_wdata;
      default: csr_new = csr_old;
    endcase
  end

  logic illegal;
  assign illegal = csr_valid && !(addr_ok && funct3_ok);

  // Interrupt selection: lowest pending-and-enabled line wins.
  logic [NUM_IRQ-1:0] irq_pend;
  logic [3:0]         irq_idx;
  logic               irq_eligible;
  logic [XLEN-1:0]    irq_cause;
  always_comb begin
    irq_pend = irq_sync2_reg & mie_reg[16 +: NUM_IRQ];
    irq_idx  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_idx = 4'(i);
    end
    irq_eligible = mstatus_mie_reg && (|irq_pend) && irq_ok;
    irq_cause = '0;
    irq_cause[XLEN-1] = 1'b1;
    irq_cause[4:0]    = {1'b1, irq_idx};
  end

  logic            exc_hit;
  logic            is_irq;
  logic [XLEN-1:0] exc_code;
  logic [XLEN-1:0] exc_tval;
  always_comb begin
    exc_hit  = 1'b1;
    is_irq   = 1'b0;
    exc_code = '0;
    exc_tval = '0;
    if (exc_instr_mis) begin
      exc_tval = exc_addr;
    end else if (illegal) begin
      exc_code = XLEN'(2);
    end else if (ebreak) begin
      exc_code = XLEN'(3);
      exc_tval = pc_ex;
    end else if (exc_load_mis) begin
      exc_code = XLEN'(4);
      exc_tval = exc_addr;
    end else if (exc_store_mis) begin
      exc_code = XLEN'(6);
      exc_tval = exc_addr;
    end else if (ecall) begin
      exc_code = XLEN'(11);
    end else if (irq_eligible) begin
      exc_code = irq_cause;
      is_irq   = 1'b1;
    end else begin
      exc_hit  = 1'b0;
    end
  end

  logic run;
  logic trap_fire;
  logic mret_fire;
  logic csr_fire;
  assign run       = (state_reg == ST_RUN);
  assign trap_fire = run && exc_hit;
  assign mret_fire = run && !exc_hit && mret;
  assign csr_fire  = run && !exc_hit && !mret && csr_valid;

  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] trap_target;
  assign mtvec_base  = {mtvec_reg[XLEN-1:2], 2'b00};
  assign trap_target = (is_irq && VECTORED_EN && mtvec_reg[0])
                     ? mtvec_base + XLEN'({1'b1, irq_idx, 2'b00})
                     : mtvec_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= '0;
      mtvec_reg        <= RESET_MTVEC;
      mscratch_reg     <= '0;
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      mtval_reg        <= '0;
      irq_sync1_reg    <= '0;
      irq_sync2_reg    <= '0;
    end else begin
      irq_sync1_reg <= irq_in;
      irq_sync2_reg <= irq_sync1_reg;
      if (trap_fire) begin
        mepc_reg         <= {pc_ex[XLEN-1:2], 2'b00};
        mcause_reg       <= exc_code;
        mtval_reg        <= exc_tval;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (mret_fire) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end else if (csr_fire && csr_wr) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie_reg  <= csr_new[3];
            mstatus_mpie_reg <= csr_new[7];
          end
          ADDR_MIE:      mie_reg      <= csr_new & irq_mask;
          ADDR_MTVEC:    mtvec_reg    <= {csr_new[XLEN-1:2], 1'b0, csr_new[0] & VECTORED_EN};
          ADDR_MSCRATCH: mscratch_reg <= csr_new;
          ADDR_MEPC:     mepc_reg     <= {csr_new[XLEN-1:2], 2'b00};
          ADDR_MCAUSE:   mcause_reg   <= csr_new;
          ADDR_MTVAL:    mtval_reg    <= csr_new;
          default: ;
        endcase
      end
    end
  end

  // REDIRECT lasts one cycle and ignores all inputs while the pipe flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_RUN;
      trap_take_reg  <= 1'b0;
      mret_take_reg  <= 1'b0;
      trap_addr_reg  <= '0;
      csr_rd_en_reg  <= 1'b0;
      csr_rd_dat_reg <= '0;
    end else begin
      csr_rd_en_reg  <= csr_fire;
      csr_rd_dat_reg <= csr_fire ? csr_old : '0;
      case (state_reg)
        ST_RUN: begin
          if (trap_fire) begin
            state_reg     <= ST_REDIRECT;
            trap_take_reg <= 1'b1;
            mret_take_reg <= 1'b0;
            trap_addr_reg <= trap_target;
          end else if (mret_fire) begin
            state_reg     <= ST_REDIRECT;
            trap_take_reg <= 1'b0;
            mret_take_reg <= 1'b1;
            trap_addr_reg <= mepc_reg;
          end else begin
            trap_take_reg <= 1'b0;
            mret_take_reg <= 1'b0;
            trap_addr_reg <= '0;
          end
        end
        default: begin
          state_reg     <= ST_RUN;
          trap_take_reg <= 1'b0;
          mret_take_reg <= 1'b0;
          trap_addr_reg <= '0;
        end
      endcase
    end
  end

  assign csr_rd_en  = csr_rd_en_reg;
  assign csr_rd_dat = csr_rd_dat_reg;
  assign trap_take  = trap_take_reg;
  assign mret_take  = mret_take_reg;
  assign trap_addr  = trap_addr_reg;

endmodule

// File: tb/tb_machine_trap_ctrl.sv
// Scoreboard bench for machine_trap_ctrl: expected CSR reads and redirects are queued when driven
// and matched against what the DUT emits one cycle later.
module tb_machine_trap_ctrl;

  localparam int K_RD   = 0;
  localparam int K_TRAP = 1;
  localparam int K_MRET = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid;
  logic [2:0]  csr_funct3;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_src_zero;
  logic        ecall, ebreak, mret;
  logic        exc_instr_mis, exc_load_mis, exc_store_mis;
  logic [31:0] exc_addr;
  logic [31:0] pc_ex;
  logic        irq_ok;
  logic [3:0]  irq_in;
  logic        csr_rd_en;
  logic [31:0] csr_rd_dat;
  logic        trap_take;
  logic        mret_take;
  logic [31:0] trap_addr;

  int n_checks = 0;
  int n_fail   = 0;

  int          exp_kind_q[$];
  logic [31:0] exp_val_q[$];
  string       exp_tag_q[$];

  machine_trap_ctrl #(.XLEN(32), .NUM_IRQ(4), .RESET_MTVEC(32'h4), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .csr_valid(csr_valid), .csr_funct3(csr_funct3), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_src_zero(csr_src_zero),
    .ecall(ecall), .ebreak(ebreak), .mret(mret),
    .exc_instr_mis(exc_instr_mis), .exc_load_mis(exc_load_mis), .exc_store_mis(exc_store_mis),
    .exc_addr(exc_addr), .pc_ex(pc_ex), .irq_ok(irq_ok), .irq_in(irq_in),
    .csr_rd_en(csr_rd_en), .csr_rd_dat(csr_rd_dat),
    .trap_take(trap_take), .mret_take(mret_take), .trap_addr(trap_addr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input int kind, input logic [31:0] val, input string tag);
    exp_kind_q.push_back(kind);
    exp_val_q.push_back(val);
    exp_tag_q.push_back(tag);
  endtask

  task automatic match_out(input int kind, input logic [31:0] val);
    int          k;
    logic [31:0] v;
    string       t;
    if (exp_kind_q.size() == 0) begin
      check_val($sformatf("unexpected_kind%0d", kind), 32'(exp_kind_q.size()), 32'd1);
    end else begin
      k = exp_kind_q.pop_front();
      v = exp_val_q.pop_front();
      t = exp_tag_q.pop_front();
      $display("txn %s kind=%0d value=0x%08h", t, kind, val);
      check_val({t, "_kind"}, 32'(kind), 32'(k));
      check_val(t, val, v);
    end
  endtask

  // Output monitor, sampling 1 time unit after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (csr_rd_en) match_out(K_RD, csr_rd_dat);
      if (trap_take) match_out(K_TRAP, trap_addr);
      if (mret_take) match_out(K_MRET, trap_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    csr_valid = 1'b0; csr_funct3 = 3'd0; csr_addr = 12'd0; csr_wdata = 32'd0; csr_src_zero = 1'b0;
    ecall = 1'b0; ebreak = 1'b0; mret = 1'b0;
    exc_instr_mis = 1'b0; exc_load_mis = 1'b0; exc_store_mis = 1'b0; exc_addr = 32'd0;
  endtask

  task automatic drive_csr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                           input logic sz);
    csr_valid = 1'b1; csr_funct3 = f3; csr_addr = a; csr_wdata = wd; csr_src_zero = sz;
  endtask

  // One CSR instruction with an expected old-value read.
  task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                        input logic sz, input logic [31:0] exp_old, input string tag);
    drive_csr(f3, a, wd, sz);
    expect_out(K_RD, exp_old, tag);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic csr_read(input logic [11:0] a, input logic [31:0] exp_val, input string tag);
    csr_op(3'd2, a, 32'd0, 1'b1, exp_val, tag);
  endtask

  // Event inputs already driven by the caller; spend the event cycle and the REDIRECT cycle.
  task automatic fire_redirect(input int kind, input logic [31:0] exp_addr, input string tag);
    expect_out(kind, exp_addr, tag);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    irq_ok = 1'b0;
    irq_in = 4'd0;
    pc_ex = 32'd0;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_rd_en", 32'(csr_rd_en), 32'd0);
    check_val("reset_rd_dat", csr_rd_dat, 32'd0);
    check_val("reset_trap_take", 32'(trap_take), 32'd0);
    check_val("reset_mret_take", 32'(mret_take), 32'd0);
    check_val("reset_trap_addr", trap_addr, 32'd0);

    // mtvec write/read, vectored mode retained
    csr_op(3'd1, 12'h305, 32'h101, 1'b0, 32'h4, "mtvec_rw_old");
    csr_read(12'h305, 32'h101, "mtvec_read");
    csr_read(12'h305, 32'h101, "mtvec_unchanged");
    csr_op(3'd6, 12'h300, 32'h8, 1'b0, 32'h1800, "mstatus_rsi_old");
    csr_read(12'h300, 32'h1808, "mstatus_mie_set");

    // ecall: exception always goes to the base
    pc_ex = 32'h80; ecall = 1'b1;
    fire_redirect(K_TRAP, 32'h100, "ecall_trap");
    csr_read(12'h341, 32'h80, "ecall_mepc");
    csr_read(12'h342, 32'd11, "ecall_mcause");
    csr_read(12'h300, 32'h1880, "ecall_mstatus");
    csr_read(12'h343, 32'h0, "ecall_mtval");

    // mscratch through RW/RC/RSI/RCI, including a suppressed write
    csr_op(3'd1, 12'h340, 32'hDEADBEEF, 1'b0, 32'h0, "mscratch_rw");
    csr_op(3'd3, 12'h340, 32'hFF, 1'b0, 32'hDEADBEEF, "mscratch_rc");
    csr_op(3'd6, 12'h340, 32'h3, 1'b0, 32'hDEADBE00, "mscratch_rsi");
    csr_op(3'd7, 12'h340, 32'h0, 1'b1, 32'hDEADBE03, "mscratch_rci_zero");
    csr_read(12'h340, 32'hDEADBE03, "mscratch_read");

    // illegal address and illegal funct3
    pc_ex = 32'h90; drive_csr(3'd1, 12'h7C0, 32'h5, 1'b0);
    fire_redirect(K_TRAP, 32'h100, "illegal_addr_trap");
    csr_read(12'h342, 32'd2, "illegal_mcause");
    csr_read(12'h300, 32'h1800, "illegal_mstatus");
    pc_ex = 32'h94; drive_csr(3'd4, 12'h340, 32'h5, 1'b0);
    fire_redirect(K_TRAP, 32'h100, "illegal_f3_trap");
    csr_read(12'h341, 32'h94, "illegal_f3_mepc");

    // mip is read-only; mie keeps only the interrupt bits
    csr_op(3'd1, 12'h344, 32'hFFFFFFFF, 1'b0, 32'h0, "mip_write_old");
    csr_read(12'h344, 32'h0, "mip_unchanged");
    csr_op(3'd6, 12'h300, 32'h8, 1'b0, 32'h1800, "irq_mie_on");
    csr_op(3'd1, 12'h304, 32'hFFFFFFFF, 1'b0, 32'h0, "mie_rw_all");
    csr_op(3'd1, 12'h304, 32'h20000, 1'b0, 32'hF0000, "mie_masked");

    // irq line 1: visible in mip, held off by irq_ok, then vectored trap
    irq_in = 4'b0010;
    repeat (3) @(negedge clk);
    csr_read(12'h344, 32'h20000, "mip_synced");
    pc_ex = 32'h300; irq_ok = 1'b1;
    expect_out(K_TRAP, 32'h144, "irq_trap");
    repeat (4) @(negedge clk);
    check_val("irq_latency", 32'(exp_kind_q.size()), 32'd0);
    irq_in = 4'd0; irq_ok = 1'b0;
    repeat (3) @(negedge clk);
    csr_read(12'h342, 32'h80000011, "irq_mcause");
    csr_read(12'h341, 32'h300, "irq_mepc");
    csr_read(12'h300, 32'h1880, "irq_mstatus");

    // load misalign beats ecall
    pc_ex = 32'h400; exc_load_mis = 1'b1; ecall = 1'b1; exc_addr = 32'h1003;
    fire_redirect(K_TRAP, 32'h100, "loadmis_trap");
    csr_read(12'h342, 32'd4, "loadmis_mcause");
    csr_read(12'h343, 32'h1003, "loadmis_mtval");

    // mret
    csr_op(3'd2, 12'h300, 32'h80, 1'b0, 32'h1800, "mpie_set");
    csr_op(3'd1, 12'h341, 32'h200, 1'b0, 32'h400, "mepc_write");
    mret = 1'b1;
    fire_redirect(K_MRET, 32'h200, "mret_take");
    csr_read(12'h300, 32'h1888, "mret_mstatus");

    // instr misalign beats an illegal CSR access in the same cycle
    pc_ex = 32'h600; exc_instr_mis = 1'b1; exc_addr = 32'h2002; drive_csr(3'd1, 12'h7FF, 32'h0, 1'b0);
    fire_redirect(K_TRAP, 32'h100, "imis_trap");
    csr_read(12'h342, 32'd0, "imis_mcause");
    csr_read(12'h343, 32'h2002, "imis_mtval");

    // direct mode, ebreak; CSR write during REDIRECT must be ignored
    csr_op(3'd1, 12'h305, 32'h200, 1'b0, 32'h101, "mtvec_direct");
    pc_ex = 32'h500; ebreak = 1'b1;
    expect_out(K_TRAP, 32'h200, "ebreak_trap");
    @(negedge clk);
    clear_inputs();
    drive_csr(3'd1, 12'h340, 32'h1234, 1'b0);
    @(negedge clk);
    clear_inputs();
    csr_read(12'h340, 32'hDEADBE03, "redirect_ignored");
    csr_read(12'h342, 32'd3, "ebreak_mcause");
    csr_read(12'h343, 32'h500, "ebreak_mtval");

    // reset while in REDIRECT
    pc_ex = 32'h700; ecall = 1'b1;
    expect_out(K_TRAP, 32'h200, "ecall_before_rst");
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_redirect_trap_take", 32'(trap_take), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_redirect_trap_addr", trap_addr, 32'd0);
    csr_read(12'h305, 32'h4, "rst_mtvec");
    csr_read(12'h300, 32'h1800, "rst_mstatus");
    csr_read(12'h304, 32'h0, "rst_mie");
    csr_read(12'h340, 32'h0, "rst_mscratch");
    csr_read(12'h341, 32'h0, "rst_mepc");
    csr_read(12'h342, 32'h0, "rst_mcause");
    csr_read(12'h343, 32'h0, "rst_mtval");
    repeat (2) @(negedge clk);
    check_val("scoreboard_drained", 32'(exp_kind_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
